// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_timer
// Brief    : Cascadable N-digit BCD down-counter with load, enable, terminal
//            count pulse and DONE/BUSY status. Define BCD_DOWN_AUTORELOAD_EN
//            to reload the preset on reaching zero instead of stopping.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_timer #(
    parameter int NDIGITS = 2
) (
    input  logic                   CLK,
    input  logic                   MR,
    input  logic                   Load,
    input  logic                   Enable,
    input  logic [4*NDIGITS-1:0]   P,
    output logic [4*NDIGITS-1:0]   Q,
    output logic                   TC,
    output logic                   Done,
    output logic                   Busy
);

    localparam int         c_W        = 4 * NDIGITS;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [c_W-1:0] r_q;
    logic [c_W-1:0] w_q_nxt;
    logic           r_tc;
    logic           w_tc_nxt;
    logic [c_W-1:0] w_p_clamp;
    logic [c_W-1:0] w_dec;
`ifdef BCD_DOWN_AUTORELOAD_EN
    logic [c_W-1:0] r_reload;
    logic [c_W-1:0] w_reload_nxt;
`endif

    // Out-of-range preset digits saturate at 9 so Q stays valid BCD.
    always_comb begin
        w_p_clamp = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            w_p_clamp[4*i +: 4] = (P[4*i +: 4] > 4'd9) ? 4'd9 : P[4*i +: 4];
        end
    end

    // Ripple borrow: a digit steps only when every lower digit is zero.
    always_comb begin : p_dec
        logic       v_borrow;
        logic [3:0] v_d;
        w_dec    = '0;
        v_borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            v_d = r_q[4*i +: 4];
            if (v_borrow) begin
                w_dec[4*i +: 4] = (v_d == 4'd0) ? 4'd9 : (v_d - 4'd1);
            end else begin
                w_dec[4*i +: 4] = v_d;
            end
            v_borrow = v_borrow & (v_d == 4'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            r_state  <= c_ST_IDLE;
            r_q      <= '0;
            r_tc     <= 1'b0;
`ifdef BCD_DOWN_AUTORELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_tc     <= w_tc_nxt;
`ifdef BCD_DOWN_AUTORELOAD_EN
            r_reload <= w_reload_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_tc_nxt     = 1'b0;
`ifdef BCD_DOWN_AUTORELOAD_EN
        w_reload_nxt = r_reload;
`endif
        if (Load) begin
            w_q_nxt     = w_p_clamp;
            w_state_nxt = (w_p_clamp == '0) ? c_ST_DONE : c_ST_RUN;
`ifdef BCD_DOWN_AUTORELOAD_EN
            w_reload_nxt = w_p_clamp;
`endif
        end else begin
            case (r_state)
                c_ST_RUN, c_ST_PAUSE: begin
                    if (Enable) begin
                        if (w_dec == '0) begin
                            w_tc_nxt = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
                            w_q_nxt     = r_reload;
                            w_state_nxt = (r_reload == '0) ? c_ST_DONE : c_ST_RUN;
`else
                            w_q_nxt     = '0;
                            w_state_nxt = c_ST_DONE;
`endif
                        end else begin
                            w_q_nxt     = w_dec;
                            w_state_nxt = c_ST_RUN;
                        end
                    end else begin
                        w_state_nxt = c_ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_comb begin
        Q    = r_q;
        TC   = r_tc;
        Done = (r_state == c_ST_DONE);
        Busy = (r_state == c_ST_RUN) || (r_state == c_ST_PAUSE);
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_down_timer
// Brief    : Directed plus randomized bench against an integer-valued model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_down_timer;

    localparam int NDIGITS = 2;
    localparam int c_W     = 4 * NDIGITS;

    logic           clk;
    logic           mr;
    logic           load;
    logic           enable;
    logic [c_W-1:0] p;
    logic [c_W-1:0] q;
    logic           tc;
    logic           done;
    logic           busy;

    int n_vec = 0;
    int n_err = 0;

    // Model: count held as a plain integer; mode 0 idle, 1 run, 2 pause, 3 done.
    int m_cnt    = 0;
    int m_mode   = 0;
    int m_reload = 0;
    bit m_tc     = 1'b0;

    bcd_down_timer #(.NDIGITS(NDIGITS)) u_dut (
        .CLK    (clk),
        .MR     (mr),
        .Load   (load),
        .Enable (enable),
        .P      (p),
        .Q      (q),
        .TC     (tc),
        .Done   (done),
        .Busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int clamp_val(input logic [c_W-1:0] pv);
        int v = 0;
        int w = 1;
        for (int i = 0; i < NDIGITS; i++) begin
            int d = int'(pv[4*i +: 4]);
            v += ((d > 9) ? 9 : d) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic [c_W-1:0] to_bcd(input int v);
        logic [c_W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < NDIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_edge(input bit i_mr, input bit i_ld, input bit i_en, input logic [c_W-1:0] i_p);
        m_tc = 1'b0;
        if (i_mr) begin
            m_cnt = 0; m_mode = 0; m_reload = 0;
        end else if (i_ld) begin
            m_cnt    = clamp_val(i_p);
            m_reload = m_cnt;
            m_mode   = (m_cnt == 0) ? 3 : 1;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (i_en) begin
                m_cnt  = m_cnt - 1;
                m_mode = 1;
                if (m_cnt == 0) begin
                    m_tc = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
                    m_cnt  = m_reload;
                    m_mode = (m_reload == 0) ? 3 : 1;
`else
                    m_mode = 3;
`endif
                end
            end else begin
                m_mode = 2;
            end
        end
    endtask

    // One clock: drive, edge, update model, sample 1 time unit later.
    task automatic step(input bit i_mr, input bit i_ld, input bit i_en, input logic [c_W-1:0] i_p);
        mr = i_mr; load = i_ld; enable = i_en; p = i_p;
        @(posedge clk);
        model_edge(i_mr, i_ld, i_en, i_p);
        #1;
        check("q",    32'(q),    32'(to_bcd(m_cnt)));
        check("tc",   32'(tc),   32'(m_tc));
        check("done", 32'(done), 32'(m_mode == 3));
        check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    endtask

    initial begin
        int tc_cnt;
        int tc_edge;
        mr = 1'b1; load = 1'b0; enable = 1'b0; p = '0;

        // Reset dominates Load.
        step(1, 1, 0, 8'h55);
        step(1, 1, 0, 8'h55);
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Load 0x23 and count all the way down.
        step(0, 1, 0, 8'h23);
        check("load_q", 32'(q), 32'h23);
        tc_cnt = 0; tc_edge = 0;
        for (int i = 1; i <= 25; i++) begin
            step(0, 0, 1, 8'h00);
            if (tc) begin tc_cnt++; tc_edge = i; end
            if (i == 3) check("borrow_q", 32'(q), 32'h20);
            if (i == 4) check("wrap_q", 32'(q), 32'h19);
        end
`ifndef BCD_DOWN_AUTORELOAD_EN
        check("tc_pulses", 32'(tc_cnt), 32'd1);
        check("tc_edge", 32'(tc_edge), 32'd23);
        check("done_end", 32'(done), 32'h1);
`endif

        // Pause holds the count.
        step(0, 1, 0, 8'h10);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00);
        check("pre_pause_q", 32'(q), 32'h07);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 8'h00);
        check("pause_q", 32'(q), 32'h07);
        check("pause_busy", 32'(busy), 32'h1);
        step(0, 0, 1, 8'h00);
        check("resume_q", 32'(q), 32'h06);

        // Load with Enable: clamped preset, no decrement.
        step(0, 1, 0, 8'h50);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
        check("pre_coll_q", 32'(q), 32'h42);
        step(0, 1, 1, 8'h9F);
        check("coll_q", 32'(q), 32'h99);
        check("coll_tc", 32'(tc), 32'h0);

        // Mid-count reset, then zero preset from idle.
        step(0, 1, 0, 8'h09);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
        check("pre_mr_q", 32'(q), 32'h05);
        step(1, 0, 1, 8'h00);
        check("mr_q", 32'(q), 32'h00);
        check("mr_tc", 32'(tc), 32'h0);
        step(0, 1, 0, 8'h00);
        check("zero_done", 32'(done), 32'h1);
        check("zero_tc", 32'(tc), 32'h0);

`ifdef BCD_DOWN_AUTORELOAD_EN
        step(0, 1, 0, 8'h03);
        tc_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 1, 8'h00);
            if (tc) tc_cnt++;
            if (i == 3) check("reload_q", 32'(q), 32'h03);
        end
        check("reload_tc_pulses", 32'(tc_cnt), 32'd3);
        check("reload_done", 32'(done), 32'h0);
`endif

        // Randomized traffic; small presets keep terminal counts frequent.
        for (int i = 0; i < 1500; i++) begin
            bit r_mr = ($urandom_range(0, 99) < 2);
            bit r_ld = ($urandom_range(0, 99) < 8);
            bit r_en = ($urandom_range(0, 99) < 75);
            logic [c_W-1:0] r_p = ($urandom_range(0, 1) == 0) ? c_W'($urandom_range(0, 8'h12))
                                                               : c_W'($urandom);
            step(r_mr, r_ld, r_en, r_p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
